// File: rtl/fractal_sync_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fractal_sync_responder                                                     |
// | Releases aligned power-of-two tile groups once all members request a level |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fractal_sync_responder #(
  parameter int N_TILES   = 16,
  parameter int LVL_WIDTH = $clog2(N_TILES) + 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_TILES-1:0]             sync_req_i,
  input  logic [N_TILES*LVL_WIDTH-1:0]   sync_lvl_i,
  output logic [N_TILES-1:0]             sync_ready_o,
  output logic [N_TILES-1:0]             sync_done_o,
  output logic [N_TILES-1:0]             sync_err_o,
  output logic [CNT_WIDTH-1:0]           bar_cnt_o,
  output logic                           busy_o
);

  localparam int c_LOG  = $clog2(N_TILES);
  localparam int c_NGRP = 2 * N_TILES - 1;

  logic [N_TILES-1:0]   r_pend;
  logic [N_TILES-1:0]   r_done;
  logic [N_TILES-1:0]   r_err;
  logic                 r_busy;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [LVL_WIDTH-1:0] r_lvl [N_TILES];

  logic [LVL_WIDTH-1:0] w_lvl_in [N_TILES];
  logic [N_TILES-1:0]   w_match  [c_LOG+1];
  logic [N_TILES-1:0]   w_rel_lv [c_LOG+1];
  logic [c_NGRP-1:0]    w_grp;
  logic [N_TILES-1:0]   w_illegal;
  logic [N_TILES-1:0]   w_rel;
  logic [N_TILES-1:0]   w_acc;
  logic [N_TILES-1:0]   w_pend_nxt;
  logic [CNT_WIDTH-1:0] w_inc;

  for (genvar t = 0; t < N_TILES; t++) begin : g_tile
    assign w_lvl_in[t]  = sync_lvl_i[t*LVL_WIDTH +: LVL_WIDTH];
    assign w_illegal[t] = r_pend[t] && (r_lvl[t] > LVL_WIDTH'(c_LOG));
  end

  // Groups of every level are packed into w_grp: level l starts at 2N - 2(N>>l).
  for (genvar l = 0; l <= c_LOG; l++) begin : g_lvl
    localparam int c_OFF  = 2 * N_TILES - 2 * (N_TILES >> l);
    localparam int c_SIZE = 1 << l;

    for (genvar t = 0; t < N_TILES; t++) begin : g_match
      assign w_match[l][t] = r_pend[t] && (r_lvl[t] == LVL_WIDTH'(l));
    end

    for (genvar g = 0; g < (N_TILES >> l); g++) begin : g_grp
      assign w_grp[c_OFF+g] = &w_match[l][g*c_SIZE +: c_SIZE];
    end

    for (genvar t = 0; t < N_TILES; t++) begin : g_rel
      assign w_rel_lv[l][t] = w_grp[c_OFF + (t >> l)];
    end
  end

  // A tile matches only its own level, so groups completing together are disjoint.
  always_comb begin
    w_rel = w_illegal;
    for (int l = 0; l <= c_LOG; l++) begin
      w_rel = w_rel | w_rel_lv[l];
    end
    w_inc = '0;
    for (int i = 0; i < c_NGRP; i++) begin
      w_inc = w_inc + CNT_WIDTH'(w_grp[i]);
    end
  end

  assign w_acc      = sync_req_i & ~r_pend;
  assign w_pend_nxt = (r_pend & ~w_rel) | w_acc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= '0;
      r_done <= '0;
      r_err  <= '0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
      for (int t = 0; t < N_TILES; t++) begin
        r_lvl[t] <= '0;
      end
    end else begin
      r_pend <= w_pend_nxt;
      r_done <= w_rel;
      r_err  <= w_illegal;
      r_busy <= |w_pend_nxt;
      r_cnt  <= r_cnt + w_inc;
      for (int t = 0; t < N_TILES; t++) begin
        if (w_acc[t]) begin
          r_lvl[t] <= w_lvl_in[t];
        end
      end
    end
  end

  assign sync_ready_o = ~r_pend;
  assign sync_done_o  = r_done;
  assign sync_err_o   = r_err;
  assign bar_cnt_o    = r_cnt;
  assign busy_o       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fractal_sync_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fractal_sync_responder                                                  |
// | Scenario bench with an expected/observed release-event scoreboard          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fractal_sync_responder;

  localparam int N   = 16;
  localparam int LW  = 5;
  localparam int CW  = 32;

  typedef struct {
    logic [N-1:0]  done;
    logic [N-1:0]  err;
    logic [CW-1:0] cnt;
    int            cyc;
  } ev_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*LW-1:0] lvl;
  logic [N-1:0]    ready;
  logic [N-1:0]    done;
  logic [N-1:0]    err;
  logic [CW-1:0]   cnt;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [CW-1:0] exp_cnt = '0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  fractal_sync_responder #(.N_TILES(N), .LVL_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sync_req_i  (req),
    .sync_lvl_i  (lvl),
    .sync_ready_o(ready),
    .sync_done_o (done),
    .sync_err_o  (err),
    .bar_cnt_o   (cnt),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every done/err pulse seen outside reset becomes an observed event.
  always @(negedge clk) begin
    if (rst_n && (done != '0 || err != '0)) begin
      ev_t e;
      e.done = done; e.err = err; e.cnt = cnt; e.cyc = cyc;
      obs_q.push_back(e);
    end
  end

  task automatic set_req(input logic [N-1:0] m, input logic [LW-1:0] l);
    for (int t = 0; t < N; t++) begin
      if (m[t]) begin
        req[t] = 1'b1;
        lvl[t*LW +: LW] = l;
      end
    end
  endtask

  task automatic expect_ev(input logic [N-1:0] d, input logic [N-1:0] e, input int n_groups, input int at);
    ev_t x;
    exp_cnt = exp_cnt + CW'(n_groups);
    x.done = d; x.err = e; x.cnt = exp_cnt; x.cyc = at;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_req(16'h0020, 5'd0);
    set_req(16'h0004, 5'd2);
    @(negedge clk);
    req = '0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 16'hFFFF || done !== '0 || err !== '0 || cnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: ready=%h done=%h err=%h cnt=%0d busy=%b, want ffff 0 0 0 0",
               ready, done, err, cnt, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() !== 0 || ready !== 16'hFFFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: events=%0d ready=%h busy=%b, want 0 ffff 0", obs_q.size(), ready, busy);
    end
    obs_q.delete();
  endtask

  task automatic test_level0();
    @(negedge clk);
    set_req(16'h0020, 5'd0);
    expect_ev(16'h0020, 16'h0000, 1, cyc + 2);
    @(negedge clk);
    checks++;
    if (ready[5] !== 1'b0 || busy !== 1'b1 || done !== '0) begin
      errors++;
      $display("FAIL l0_pending: ready5=%b busy=%b done=%h, want 0 1 0", ready[5], busy, done);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (ready[5] !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL l0_ready_back: ready5=%b busy=%b, want 1 0", ready[5], busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_level2_group();
    @(negedge clk); set_req(16'h0010, 5'd2);
    @(negedge clk); req = '0;
    @(negedge clk); set_req(16'h0020, 5'd2);
    @(negedge clk); req = '0; set_req(16'h0040, 5'd2);
    @(negedge clk); req = '0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ready[7:4] !== 4'b1000 || obs_q.size() !== 0) begin
      errors++;
      $display("FAIL l2_partial: busy=%b ready74=%b events=%0d, want 1 1000 0", busy, ready[7:4], obs_q.size());
    end
    set_req(16'h0080, 5'd2);
    expect_ev(16'h00F0, 16'h0000, 1, cyc + 2);
    @(negedge clk); req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_full_mesh();
    @(negedge clk);
    set_req(16'hFFFF, 5'd4);
    expect_ev(16'hFFFF, 16'h0000, 1, cyc + 2);
    @(negedge clk); req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    set_req(16'h0003, 5'd1);
    set_req(16'hFF00, 5'd3);
    expect_ev(16'hFF03, 16'h0000, 2, cyc + 2);
    @(negedge clk); req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mixed_levels();
    @(negedge clk);
    set_req(16'h0001, 5'd1);
    set_req(16'h0002, 5'd0);
    expect_ev(16'h0002, 16'h0000, 1, cyc + 2);
    @(negedge clk); req = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (ready[0] !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mixed_stuck: ready0=%b busy=%b, want 0 1", ready[0], busy);
    end
    set_req(16'h0002, 5'd1);
    expect_ev(16'h0003, 16'h0000, 1, cyc + 2);
    @(negedge clk); req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_illegal();
    @(negedge clk);
    set_req(16'h0008, 5'd5);
    expect_ev(16'h0008, 16'h0008, 0, cyc + 2);
    expect_ev(16'h0008, 16'h0008, 0, cyc + 4);
    @(negedge clk);
    checks++;
    if (ready[3] !== 1'b0) begin
      errors++;
      $display("FAIL illegal_hold: ready3=%b, want 0", ready[3]);
    end
    @(negedge clk);
    checks++;
    if (ready[3] !== 1'b1) begin
      errors++;
      $display("FAIL illegal_released: ready3=%b, want 1", ready[3]);
    end
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ready !== 16'hFFFF) begin
      errors++;
      $display("FAIL idle_end: busy=%b ready=%h, want 0 ffff", busy, ready);
    end
  endtask

  // Pops every expected release and pairs it with the next observed one.
  task automatic test_scoreboard(input string name);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: events=%0d, want %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev_t x, o;
      x = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.done !== x.done || o.err !== x.err || o.cnt !== x.cnt || o.cyc !== x.cyc) begin
        errors++;
        $display("FAIL %s_event: done=%h err=%h cnt=%0d cyc=%0d, want %h %h %0d %0d",
                 name, o.done, o.err, o.cnt, o.cyc, x.done, x.err, x.cnt, x.cyc);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    lvl   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    exp_cnt = '0;
    test_level0();        test_scoreboard("level0");
    test_level2_group();  test_scoreboard("level2");
    test_full_mesh();     test_scoreboard("full_mesh");
    test_simultaneous();  test_scoreboard("simultaneous");
    test_mixed_levels();  test_scoreboard("mixed");
    test_illegal();       test_scoreboard("illegal");
    checks++;
    if (cnt !== exp_cnt) begin
      errors++;
      $display("FAIL final_count: cnt=%0d, want %0d", cnt, exp_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
